alarm_timer: RTL and testbench
==============================

ALARM_TIMER -- requirements
Module: alarm_timer

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_SEC, default 100, the clock cycles per one-second tick (minimum 2).
REQ-002 The block SHALL have port clock  input  1  the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port reprogram  input  1  write strobe for the parameter table.
REQ-005 The block SHALL have port time_param_sel  input  2  table entry to write (0 T_ARM_DELAY, 1 T_DRIVER_DELAY, 2 T_PASSENGER_DELAY, 3 T_ALARM_ON).
REQ-006 The block SHALL have port time_value  input  4  seconds value to write.
REQ-007 The block SHALL have port start_timer  input  1  one-cycle start request from the anti-theft FSM.
REQ-008 The block SHALL have port interval_sel  input  2  table entry that sets the countdown length; sampled only with start_timer.
REQ-009 The block SHALL have port expired  output  1  registered one-cycle pulse at end of countdown.
REQ-010 The block SHALL have port busy  output  1  registered; high while a countdown runs.
REQ-011 The block SHALL have port remaining  output  4  registered seconds left in the current countdown.
REQ-012 The block SHALL have port one_hz_enable  output  1  high for one cycle when div_cnt = CYCLES_PER_SEC-1.

Function
REQ-013 Parameter table SHALL hold four 4-bit entries; when reprogram=1, entry[time_param_sel] SHALL take time_value at that edge.
REQ-014 Divider div_cnt SHALL count 0..CYCLES_PER_SEC-1 and wrap to 0; it free-runs when idle.
REQ-015 When start_timer=1, div_cnt SHALL load 0 at that edge, so the first second is a full CYCLES_PER_SEC cycles.
REQ-016 When start_timer=1 with entry[interval_sel]=N>0, remaining SHALL load N and busy SHALL become 1 at that edge.
REQ-017 When start_timer=1 with N=0, expired SHALL be 1 for the next cycle only, busy SHALL stay 0 and remaining SHALL be 0.
REQ-018 While busy, each one_hz_enable edge SHALL decrement remaining by 1.
REQ-019 On the edge where remaining=1 and one_hz_enable=1, remaining SHALL become 0, busy SHALL become 0 and expired SHALL become 1 for exactly one cycle.
REQ-020 Latency: for a start at edge k with N>0, expired SHALL be high in the cycle after edge k+N*CYCLES_PER_SEC.
REQ-021 start_timer while busy SHALL restart: reload from the new interval_sel and reset div_cnt; no expired pulse for the aborted count.
REQ-022 start_timer and one_hz_enable in the same cycle: start SHALL win; no decrement or expiry.
REQ-023 reprogram and start_timer in the same cycle on the same entry: the countdown SHALL use the pre-write value; the table SHALL still update.
REQ-024 reprogram during a countdown SHALL NOT change remaining.
REQ-025 remaining SHALL never underflow; it stays 0 when idle.

Reset
REQ-026 On reset=1 at an edge, the table SHALL load T_ARM_DELAY=6, T_DRIVER_DELAY=8, T_PASSENGER_DELAY=15, T_ALARM_ON=10.
REQ-027 On reset, div_cnt, remaining, busy and expired SHALL all be 0; one_hz_enable is therefore 0.
REQ-028 Reset SHALL override start_timer and reprogram in the same cycle and abort a running countdown with no expired pulse.

Verification (CYCLES_PER_SEC=4)
REQ-029 Reset, start_timer with interval_sel=0 -> busy=1, remaining=6; remaining steps 5..0 every 4 cycles; expired is a one-cycle pulse 24 cycles after start; busy=0.
REQ-030 reprogram sel=1 value=3, then start sel=1 -> expired 12 cycles after start; the same-cycle write/start case uses the old value 8 (32 cycles).
REQ-031 Write 0 to sel=3, start sel=3 -> expired the next cycle; busy never 1.
REQ-032 Start sel=2 (15), restart with sel=1 (8) after 10 cycles -> expired only 32 cycles after the restart; no earlier pulse.
REQ-033 Reset asserted mid-countdown -> busy, remaining and expired are 0 next cycle; the table returns to 6/8/15/10.
REQ-034 Idle -> one_hz_enable pulses exactly every 4 cycles; a start forces the next pulse to come 4 cycles after the start edge.

Source files
------------

// File: rtl/alarm_timer.sv
// Countdown timer for the anti-theft FSM: programmable 4-entry seconds table,
// one-second divider, and a one-cycle expiry pulse.
module alarm_timer #(
   parameter int CYCLES_PER_SEC = 100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       reprogram,
   input  logic [1:0] time_param_sel,
   input  logic [3:0] time_value,
   input  logic       start_timer,
   input  logic [1:0] interval_sel,
   output logic       expired,
   output logic       busy,
   output logic [3:0] remaining,
   output logic       one_hz_enable
);

   localparam int DW = $clog2(CYCLES_PER_SEC);
   localparam logic [DW-1:0] DIV_LAST = DW'(CYCLES_PER_SEC - 1);

   localparam logic [3:0] T_ARM_DELAY       = 4'd6;
   localparam logic [3:0] T_DRIVER_DELAY    = 4'd8;
   localparam logic [3:0] T_PASSENGER_DELAY = 4'd15;
   localparam logic [3:0] T_ALARM_ON        = 4'd10;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      tbl_q [4];
   logic [DW-1:0]   div_q, div_d;
   logic [3:0]      rem_q, rem_d;
   logic            exp_q, exp_d;
   logic [3:0]      start_n;

   // Table read happens before any same-cycle write lands.
   assign start_n       = tbl_q[interval_sel];
   assign one_hz_enable = (div_q == DIV_LAST);
   assign busy          = (state_q == RUN);
   assign remaining     = rem_q;
   assign expired       = exp_q;

   always_comb begin
      state_d = state_q;
      div_d   = one_hz_enable ? '0 : div_q + 1'b1;
      rem_d   = rem_q;
      exp_d   = 1'b0;
      if (start_timer) begin
         div_d = '0;
         if (start_n != 4'd0) begin
            state_d = RUN;
            rem_d   = start_n;
         end else begin
            state_d = IDLE;
            rem_d   = 4'd0;
            exp_d   = 1'b1;
         end
      end else if (state_q == RUN && one_hz_enable) begin
         rem_d = rem_q - 4'd1;
         if (rem_q == 4'd1) begin
            state_d = IDLE;
            exp_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         div_q    <= '0;
         rem_q    <= 4'd0;
         exp_q    <= 1'b0;
         tbl_q[0] <= T_ARM_DELAY;
         tbl_q[1] <= T_DRIVER_DELAY;
         tbl_q[2] <= T_PASSENGER_DELAY;
         tbl_q[3] <= T_ALARM_ON;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         exp_q   <= exp_d;
         if (reprogram) begin
            tbl_q[time_param_sel] <= time_value;
         end
      end
   end

endmodule

// File: tb/tb_alarm_timer.sv
// Bench for alarm_timer: vector table of writes/starts, expiry scoreboard,
// per-cycle busy/remaining/one_hz_enable expectations from start times.
module tb_alarm_timer;

   localparam int CPS = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       reprogram = 1'b0;
   logic [1:0] time_param_sel = 2'd0;
   logic [3:0] time_value = 4'd0;
   logic       start_timer = 1'b0;
   logic [1:0] interval_sel = 2'd0;
   logic       expired;
   logic       busy;
   logic [3:0] remaining;
   logic       one_hz_enable;

   always #5 clock = ~clock;

   alarm_timer #(.CYCLES_PER_SEC(CPS)) dut (
      .clock         (clock),
      .reset         (reset),
      .reprogram     (reprogram),
      .time_param_sel(time_param_sel),
      .time_value    (time_value),
      .start_timer   (start_timer),
      .interval_sel  (interval_sel),
      .expired       (expired),
      .busy          (busy),
      .remaining     (remaining),
      .one_hz_enable (one_hz_enable)
   );

   typedef struct {
      logic       rs;
      logic       rp;
      logic [1:0] psel;
      logic [3:0] pval;
      logic       st;
      logic [1:0] isel;
      int         n;
      int         hold;
   } vec_t;

   vec_t vecs[$];
   int   due_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   exp_n = 0;
   bit   running = 1'b0;
   int   run_start = 0;
   int   run_n = 0;
   int   div_ref = 0;

   function automatic vec_t mk(input logic rs, input logic rp,
                               input int psel, input int pval,
                               input logic st, input int isel,
                               input int n, input int hold);
      vec_t v;
      v.rs   = rs;
      v.rp   = rp;
      v.psel = 2'(psel);
      v.pval = 4'(pval);
      v.st   = st;
      v.isel = 2'(isel);
      v.n    = n;
      v.hold = hold;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                  nm, cyc, act, exp);
      end
   endtask

   // One clock: capture what was driven into this edge, then compare.
   task automatic tick();
      logic rs_s;
      logic st_s;
      int   rem_i;
      bit   exp_e;
      rs_s = reset;
      st_s = start_timer;
      @(posedge clock);
      #1;
      cyc++;
      rem_i = 0;
      if (rs_s) begin
         running = 1'b0;
         div_ref = cyc;
         due_q.delete();
      end else if (st_s) begin
         div_ref = cyc;
         due_q.delete();
         due_q.push_back(cyc + exp_n * CPS);
         running   = (exp_n > 0);
         run_start = cyc;
         run_n     = exp_n;
      end
      if (running) begin
         rem_i = run_n - (cyc - run_start) / CPS;
         if (rem_i <= 0) begin
            running = 1'b0;
            rem_i   = 0;
         end
      end
      exp_e = (due_q.size() > 0) && (due_q[0] == cyc);
      if (exp_e) void'(due_q.pop_front());
      chk("busy", int'(busy), int'(running));
      chk("remaining", int'(remaining), rem_i);
      chk("expired", int'(expired), int'(exp_e));
      chk("one_hz_enable", int'(one_hz_enable),
          int'(((cyc - div_ref) % CPS) == CPS - 1));
   endtask

   task automatic apply(input vec_t v);
      reset          = v.rs;
      reprogram      = v.rp;
      time_param_sel = v.psel;
      time_value     = v.pval;
      start_timer    = v.st;
      interval_sel   = v.isel;
      exp_n          = v.n;
      tick();
      reset       = 1'b0;
      reprogram   = 1'b0;
      start_timer = 1'b0;
      repeat (v.hold) tick();
   endtask

   initial begin
      //           rs rp ps pv st is  n hold
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 6, 27));
      vecs.push_back(mk(0, 0, 0, 0, 1, 2, 15, 9));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 8, 5));
      vecs.push_back(mk(0, 1, 1, 12, 0, 0, 0, 30));
      vecs.push_back(mk(0, 1, 1, 8, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 3, 1, 1, 8, 35));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 7));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 14));
      vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 4));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 6));

      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (8) tick();

      foreach (vecs[i]) apply(vecs[i]);

      // Reset mid-countdown, colliding with a start and a write.
      apply(mk(0, 0, 0, 0, 1, 2, 15, 5));
      apply(mk(1, 1, 0, 2, 1, 2, 15, 3));

      // Every entry must be back at its reset value.
      apply(mk(0, 0, 0, 0, 1, 0, 6, 1));
      apply(mk(0, 0, 0, 0, 1, 1, 8, 1));
      apply(mk(0, 0, 0, 0, 1, 2, 15, 1));
      apply(mk(0, 0, 0, 0, 1, 3, 10, 42));

      chk("pending_expiry", due_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
